// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RISC-V funct3 access-type encodings
//   - FSM state enum
//   - access_bad(): flags illegal or misaligned requests
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } lsu_state_e;

  // Returns 1 for encodings with no access type, for stores of the unsigned
  // load variants, and for halfword/word accesses off their natural boundary.
  function automatic logic access_bad(input logic write, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = write;
      F3_HU:   bad = write | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundles the pipeline request/response and data-memory bus of the
// load/store unit.
//   master : requester + data memory side (drives request and mem_data_out)
//   slave  : the load/store unit itself
interface lsu_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30
) ();

  logic                     req_valid;
  logic                     req_write;
  logic [2:0]               funct3;
  logic [31:0]              addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     mem_read_En;
  logic                     mem_write_En;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_data_in;
  logic [DATA_WIDTH-1:0]    mem_data_out;

  modport master (
    output req_valid, req_write, funct3, addr, wdata, mem_data_out,
    input  busy, done, err, rdata, mem_read_En, mem_write_En, mem_address, mem_data_in
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata, mem_data_out,
    output busy, done, err, rdata, mem_read_En, mem_write_En, mem_address, mem_data_in
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the load/store unit.
//   funct3     : access type of the latched request
//   byte_off   : addr[1:0] of the latched request
//   mem_word   : word read from data memory
//   wdata      : right-aligned store data
//   load_data  : selected lane, sign/zero extended (word passes through)
//   store_word : mem_word with the addressed lane replaced by store data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            byte_off,
  input  logic [DATA_WIDTH-1:0] mem_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfword lanes only start at bit 0 or 16, so addr[0] is ignored there.
  assign byte_sh   = {byte_off, 3'b000};
  assign half_sh   = {byte_off[1], 4'b0000};
  assign byte_lane = mem_word[byte_sh +: 8];
  assign half_lane = mem_word[half_sh +: 16];

  // Load extraction and extension.
  always_comb begin
    load_data = mem_word;
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_H:    load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: load_data = mem_word;
    endcase
  end

  // Read-modify-write merge; untouched lanes keep their memory contents.
  always_comb begin
    store_word = mem_word;
    case (funct3)
      F3_B:    store_word[byte_sh +: 8]  = wdata[7:0];
      F3_H:    store_word[half_sh +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between a pipeline
// and a word-addressed synchronous data memory.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : lsu_if.slave carrying request (req_valid/req_write/funct3/
//              addr/wdata), response (busy/done/err/rdata) and memory port
//              (mem_read_En/mem_write_En/mem_address/mem_data_in/mem_data_out)
// Loads take READ->WAIT, word stores go straight to WRITE, byte/half stores
// read-merge-write through READ->WAIT->WRITE. Bad requests finish from IDLE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30
) (
  input logic clk,
  input logic rst,
  lsu_if.slave bus
);

  lsu_state_e               state_q, state_d;
  logic                     write_q, write_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [1:0]               off_q, off_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]    mem_data_in_q, mem_data_in_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [DATA_WIDTH-1:0]    load_data_s;
  logic [DATA_WIDTH-1:0]    store_word_s;

  // mem_data_in_q still holds the latched store data until WAIT overwrites
  // it with the merged word, so it doubles as the store-data source.
  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (funct3_q),
    .byte_off   (off_q),
    .mem_word   (bus.mem_data_out),
    .wdata      (mem_data_in_q),
    .load_data  (load_data_s),
    .store_word (store_word_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      rdata_q       <= rdata_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // Next-state and register-load selection.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    rdata_d       = rdata_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d       = bus.req_write;
          funct3_d      = bus.funct3;
          off_d         = bus.addr[1:0];
          mem_address_d = bus.addr[ADDRESS_WIDTH+1:2];
          mem_data_in_d = bus.wdata;
          if (access_bad(bus.req_write, bus.funct3, bus.addr[1:0])) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (bus.req_write && (bus.funct3 == F3_W)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Memory word is valid now: finish a load or stage the merged store.
        if (write_q) begin
          mem_data_in_d = store_word_s;
          state_d       = ST_WRITE;
        end else begin
          rdata_d = load_data_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.mem_read_En  = (state_q == ST_READ);
  assign bus.mem_write_En = (state_q == ST_WRITE);
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_data_in  = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a byte-arithmetic reference model and a 256-word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30)) bus ();

  load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous data memory driven by the DUT, plus a preload port.
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else begin
      if (bus.mem_write_En) mem[bus.mem_address[7:0]] <= bus.mem_data_in;
      if (bus.mem_read_En) bus.mem_data_out <= mem[bus.mem_address[7:0]];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic        cur_w;
  logic [2:0]  cur_f3;
  logic [31:0] cur_a;
  logic [31:0] cur_wd;
  logic [31:0] exp_rdata;

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic present(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    cur_w  = w;
    cur_f3 = f3;
    cur_a  = a;
    cur_wd = wd;
    bus.req_write = w;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.req_valid = 1'b1;
  endtask

  // Waits for done on the presented request and checks it against the model.
  // Leaves req_valid asserted; the caller drops it or presents the next one.
  task automatic finish_txn(input string tag);
    int n, rd_cnt, wr_cnt, both_cnt, busy_cnt, addr_bad;
    int size, sh, exp_lat, exp_rd, exp_wr;
    logic got_done, illegal, mis;
    logic [31:0] mask, word, val;
    logic [7:0] wi;
    n = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0; busy_cnt = 0; addr_bad = 0;
    got_done = 1'b0;
    while (n < 12 && !got_done) begin
      @(posedge clk); #1;
      n++;
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.mem_read_En === 1'b1) rd_cnt++;
        if (bus.mem_write_En === 1'b1) wr_cnt++;
        if (bus.mem_read_En === 1'b1 && bus.mem_write_En === 1'b1) both_cnt++;
        if ((bus.mem_read_En === 1'b1 || bus.mem_write_En === 1'b1) &&
            ({bus.mem_address, 2'b00} !== {cur_a[31:2], 2'b00})) addr_bad++;
      end
    end
    check($sformatf("%s.done_seen", tag), 32'(got_done), 32'd1);

    // Reference model: plain byte arithmetic on the reference memory.
    illegal = (cur_f3 == 3'd3) || (cur_f3 == 3'd6) || (cur_f3 == 3'd7) ||
              (cur_w && (cur_f3 == 3'd4 || cur_f3 == 3'd5));
    size = (cur_f3[1:0] == 2'd0) ? 1 : ((cur_f3[1:0] == 2'd1) ? 2 : 4);
    mis  = (int'(cur_a[1:0]) % size) != 0;
    sh   = int'(cur_a[1:0]) * 8;
    mask = (size == 1) ? 32'h0000_00FF : ((size == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    wi   = cur_a[9:2];
    word = ref_mem[wi];
    if (illegal || mis) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!cur_w) begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0;
      val = (word >> sh) & mask;
      if (!cur_f3[2] && size < 4 && (val & ((mask >> 1) + 32'd1)) != 32'd0) val = val | ~mask;
      exp_rdata = val;
    end else begin
      exp_lat = (size == 4) ? 2 : 4;
      exp_rd  = (size == 4) ? 0 : 1;
      exp_wr  = 1;
      ref_mem[wi] = (word & ~(mask << sh)) | ((cur_wd & mask) << sh);
    end

    check($sformatf("%s.latency", tag), 32'(n), 32'(exp_lat));
    check($sformatf("%s.err", tag), 32'(bus.err), 32'((illegal || mis) ? 1 : 0));
    check($sformatf("%s.rdata", tag), bus.rdata, exp_rdata);
    check($sformatf("%s.rd_cycles", tag), 32'(rd_cnt), 32'(exp_rd));
    check($sformatf("%s.wr_cycles", tag), 32'(wr_cnt), 32'(exp_wr));
    check($sformatf("%s.both_en", tag), 32'(both_cnt), 32'd0);
    check($sformatf("%s.busy_cycles", tag), 32'(busy_cnt), 32'(exp_lat - 1));
    check($sformatf("%s.busy_at_done", tag), 32'(bus.busy), 32'd0);
    check($sformatf("%s.mem_addr", tag), 32'(addr_bad), 32'd0);
    check($sformatf("%s.mem_word", tag), mem[wi], ref_mem[wi]);
  endtask

  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    present(w, f3, a, wd);
    finish_txn(tag);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s.done_one_cycle", tag), 32'(bus.done), 32'd0);
  endtask

  task automatic rand_req(output logic w, output logic [2:0] f3, output logic [31:0] a,
                          output logic [31:0] wd);
    logic [2:0] legal [5];
    legal[0] = F3_B; legal[1] = F3_H; legal[2] = F3_W; legal[3] = F3_BU; legal[4] = F3_HU;
    w  = 1'($urandom_range(0, 1));
    f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
    a  = 32'($urandom_range(0, 1023));
    wd = $urandom;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        nw;
    logic [2:0]  nf3;
    logic [31:0] na, nwd;

    rst = 1'b1;
    pre_we = 1'b0; pre_a = 8'd0; pre_d = 32'd0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.funct3 = 3'b000;
    bus.addr = 32'd0; bus.wdata = 32'd0;
    exp_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) preload(i[7:0], $urandom);
    preload(8'h40, 32'h8899_AABB);

    // Reset state.
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.err", 32'(bus.err), 32'd0);
    check("rst.rdata", bus.rdata, 32'd0);
    check("rst.rd_en", 32'(bus.mem_read_En), 32'd0);
    check("rst.wr_en", 32'(bus.mem_write_En), 32'd0);
    check("rst.mem_address", 32'(bus.mem_address), 32'd0);
    check("rst.mem_data_in", bus.mem_data_in, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loads from the preloaded word.
    txn(1'b0, F3_W, 32'h100, 32'd0, "lw");
    check("lw.value", bus.rdata, 32'h8899_AABB);
    txn(1'b0, F3_B, 32'h103, 32'd0, "lb");
    check("lb.value", bus.rdata, 32'hFFFF_FF88);
    txn(1'b0, F3_BU, 32'h103, 32'd0, "lbu");
    check("lbu.value", bus.rdata, 32'h0000_0088);
    txn(1'b0, F3_H, 32'h102, 32'd0, "lh");
    check("lh.value", bus.rdata, 32'hFFFF_8899);
    txn(1'b0, F3_HU, 32'h100, 32'd0, "lhu");
    check("lhu.value", bus.rdata, 32'h0000_AABB);

    // Stores.
    txn(1'b1, F3_B, 32'h101, 32'h0000_00CC, "sb");
    check("sb.value", mem[8'h40], 32'h8899_CCBB);
    txn(1'b1, F3_H, 32'h102, 32'h0000_1234, "sh");
    check("sh.value", mem[8'h40], 32'h1234_CCBB);
    txn(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, "sw");
    check("sw.value", mem[8'h40], 32'hDEAD_BEEF);

    // Misaligned / illegal accesses.
    txn(1'b0, F3_W, 32'h102, 32'd0, "lw_mis");
    txn(1'b1, F3_H, 32'h101, 32'h0000_5555, "sh_mis");
    txn(1'b0, 3'b011, 32'h100, 32'd0, "f3_011");
    txn(1'b1, F3_BU, 32'h100, 32'h0000_0077, "sbu_illegal");
    check("illegal.mem_unchanged", mem[8'h40], 32'hDEAD_BEEF);

    // Reset while a byte store waits on its read.
    preload(8'h40, 32'h8899_AABB);
    present(1'b1, F3_B, 32'h100, 32'h0000_0055);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.busy_in_wait", 32'(bus.busy), 32'd1);
    check("abort.wr_en_in_wait", 32'(bus.mem_write_En), 32'd0);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.err", 32'(bus.err), 32'd0);
    check("abort.rdata", bus.rdata, 32'd0);
    check("abort.rd_en", 32'(bus.mem_read_En), 32'd0);
    check("abort.wr_en", 32'(bus.mem_write_En), 32'd0);
    check("abort.mem_address", 32'(bus.mem_address), 32'd0);
    check("abort.mem_data_in", bus.mem_data_in, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort.no_done", 32'(bus.done), 32'd0);
    check("abort.wr_en_after", 32'(bus.mem_write_En), 32'd0);
    check("abort.word_kept", mem[8'h40], 32'h8899_AABB);
    exp_rdata = 32'd0;
    txn(1'b0, F3_W, 32'h100, 32'd0, "abort.lw_after");
    check("abort.lw_value", bus.rdata, 32'h8899_AABB);

    // Back-to-back: SW presented in the LW done cycle.
    present(1'b0, F3_W, 32'h100, 32'd0);
    finish_txn("b2b.lw");
    check("b2b.lw_value", bus.rdata, 32'h8899_AABB);
    present(1'b1, F3_W, 32'h104, 32'h0BAD_F00D);
    finish_txn("b2b.sw");
    check("b2b.sw_value", mem[8'h41], 32'h0BAD_F00D);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic, mixing idle gaps and zero-bubble chaining.
    rand_req(nw, nf3, na, nwd);
    present(nw, nf3, na, nwd);
    for (int k = 0; k < 300; k++) begin
      finish_txn("rnd");
      rand_req(nw, nf3, na, nwd);
      if ($urandom_range(0, 1) == 0) begin
        present(nw, nf3, na, nwd);
      end else begin
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("rnd.done_one_cycle", 32'(bus.done), 32'd0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        present(nw, nf3, na, nwd);
      end
    end
    finish_txn("rnd");
    bus.req_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) check($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32, data word width in bits.
REQ-002 Parameter ADDRESS_WIDTH, 30, word-address width presented to data memory.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req_valid  input  1  pipeline request strobe; sampled only when busy=0.
REQ-006 Port req_write  input  1  1=store, 0=load.
REQ-007 Port funct3  input  3  RISC-V access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Port addr  input  32  byte address.
REQ-009 Port wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-010 Port busy  output  1  high whenever state != IDLE; pipeline stall.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port err  output  1  qualifies done; misaligned or illegal access.
REQ-013 Port rdata  output  DATA_WIDTH  load result, extended; held until next load completes.
REQ-014 Port mem_read_En, mem_write_En  output  1 each  data-memory enables; never both high.
REQ-015 Port mem_address  output  ADDRESS_WIDTH  equals latched addr[31:2].
REQ-016 Port mem_data_in  output  DATA_WIDTH  word written to memory.
REQ-017 Port mem_data_out  input  DATA_WIDTH  memory read word, valid the cycle after the read edge.

Function
REQ-018 States IDLE, READ, WAIT, WRITE; enables decoded from state: READ -> mem_read_En=1, WRITE -> mem_write_En=1.
REQ-019 Accept at edge E0 when state=IDLE and req_valid=1; latch req_write, funct3, addr, wdata.
REQ-020 Illegal = funct3 in {011,110,111}, or store with funct3 in {100,101}; misaligned = H/HU with addr[0]=1, W with addr[1:0]!=0.
REQ-021 Illegal/misaligned: stay IDLE, no memory enable, done=err=1 in the cycle after E0, rdata unchanged.
REQ-022 Load: IDLE->READ->WAIT->IDLE; rdata captured at end of WAIT; done high in cycle after E2 (accept-to-done 3 edges).
REQ-023 Load extraction: lane = addr[1:0]*8 (byte) or addr[1]*16 (half); B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-024 SW: IDLE->WRITE->IDLE; mem_data_in=wdata; done in cycle after E1.
REQ-025 SB/SH: IDLE->READ->WAIT->WRITE->IDLE; WAIT registers memory word with selected lane replaced by wdata[7:0] or wdata[15:0]; other lanes preserved; done after 4 edges.
REQ-026 done and err are registered, one cycle wide; err=0 on every successful completion.
REQ-027 A request presented during the done cycle (state=IDLE) is accepted; back-to-back with zero bubbles.
REQ-028 req_valid while busy=1 ignored; requester holds request until done.
REQ-029 mem_address, mem_data_in stable for the whole READ/WRITE cycle.

Reset
REQ-030 rst=1 forces state IDLE and busy, done, err, rdata, mem_read_En, mem_write_En, mem_address, mem_data_in to 0 asynchronously.
REQ-031 rst during READ/WAIT/WRITE aborts the access; a partial store performs no memory write unless its WRITE edge occurred before rst rose; no done pulse for the aborted request.

Structure
REQ-032 Package lsu_pkg holds funct3 encodings and the state enum type.
REQ-033 Combinational sub-module lsu_align performs lane select, extension, and store merge; FSM and registers live in load_store_unit.

Verification
REQ-034 Preload word 0x40 = 0x8899AABB; LW addr 0x100 -> mem_read_En one cycle, done 3 edges after accept, rdata=0x8899AABB, err=0.
REQ-035 LB 0x103 -> 0xFFFFFF88; LBU 0x103 -> 0x00000088; LH 0x102 -> 0xFFFF8899; LHU 0x100 -> 0x0000AABB.
REQ-036 SB 0x101 wdata 0x000000CC -> word 0x8899CCBB, done 4 edges after accept; then SH 0x102 wdata 0x00001234 -> 0x1234CCBB; SW 0x100 0xDEADBEEF -> done 2 edges.
REQ-037 LW 0x102, SH 0x101, funct3=011 -> done=err=1 one edge after accept, no enable asserted, memory unchanged.
REQ-038 SB 0x100 with rst pulsed in WAIT -> mem_write_En never high, word stays 0x8899AABB, all outputs 0, next LW accepted normally.
REQ-039 LW 0x100 followed by SW 0x104 presented in the done cycle -> accepted that edge, no idle bubble, both complete correctly.
